// File: rtl/bram_delay_var_if.sv
// rtl/bram_delay_var_if.sv - stream/control bundle for the programmable BRAM delay line
// Signals:
//   ce            clock enable from the stream source
//   delay         requested delay D in ce cycles (ADDR_WIDTH+1 bits)
//   delay_load    latch delay and restart the fill
//   din           data input word
//   dout          delayed word, 0 while dout_valid=0
//   dout_valid    tap holds D samples of history since the last load/reset
//   delay_clamped pulse: the last loaded delay was clamped into range
interface bram_delay_var_if #(
    parameter int WIDTH      = 128,
    parameter int ADDR_WIDTH = 10
);
    logic                  ce;
    logic [ADDR_WIDTH:0]   delay;
    logic                  delay_load;
    logic [WIDTH-1:0]      din;
    logic [WIDTH-1:0]      dout;
    logic                  dout_valid;
    logic                  delay_clamped;

    modport master (
        output ce, delay, delay_load, din,
        input  dout, dout_valid, delay_clamped
    );

    modport slave (
        input  ce, delay, delay_load, din,
        output dout, dout_valid, delay_clamped
    );
endinterface

// File: rtl/bram_delay_var.sv
// rtl/bram_delay_var.sv - runtime-programmable BRAM delay line with fill tracking
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    bram_delay_var_if.slave: ce, delay, delay_load, din in; dout, dout_valid, delay_clamped out
module bram_delay_var #(
    parameter int WIDTH         = 128,
    parameter int ADDR_WIDTH    = 10,
    parameter int LATENCY       = 2,
    parameter int DEFAULT_DELAY = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bram_delay_var_if.slave      bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   D_MIN   = (ADDR_WIDTH+1)'(LATENCY + 1);
    localparam logic [ADDR_WIDTH:0]   D_MAX   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   D_DEF   = (ADDR_WIDTH+1)'(DEFAULT_DELAY);
    localparam logic [ADDR_WIDTH-1:0] LAT_A   = ADDR_WIDTH'(LATENCY);

    typedef enum logic {S_FILL, S_RUN} state_t;

    logic [WIDTH-1:0]      mem [DEPTH];

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH:0]   fill_cnt_q, fill_cnt_d;
    logic [ADDR_WIDTH:0]   d_reg_q, d_reg_d;
    logic [WIDTH-1:0]      dout_q, dout_d;
    logic                  clamped_q, clamped_d;

    logic [ADDR_WIDTH:0]   d_load;
    logic                  clamp_hit;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [WIDTH-1:0]      mem_rdata;
    logic [WIDTH-1:0]      rd_last;

    // Reading LATENCY slots ahead of (wptr - D) makes the word leave the
    // pipeline exactly D ce cycles after it was written. D=DEPTH folds to 0
    // in the low bits, which is the intended modulo behaviour.
    assign raddr     = wptr_q - d_reg_q[ADDR_WIDTH-1:0] + LAT_A;
    assign mem_rdata = mem[raddr];

    // Simple dual-port storage; D >= LATENCY+1 keeps raddr off wptr.
    always_ff @(posedge clk) begin
        if (bus.ce) begin
            mem[wptr_q] <= bus.din;
        end
    end

    // dout_q is the final read-pipeline stage; a 2-cycle BRAM adds one
    // un-gated stage in front of it.
    generate
        if (LATENCY == 2) begin : g_lat2
            logic [WIDTH-1:0] rd_mem_q;
            always_ff @(posedge clk) begin
                if (bus.ce) begin
                    rd_mem_q <= mem_rdata;
                end
            end
            assign rd_last = rd_mem_q;
        end else begin : g_lat1
            assign rd_last = mem_rdata;
        end
    endgenerate

    always_comb begin
        d_load    = bus.delay;
        clamp_hit = 1'b0;
        if (bus.delay < D_MIN) begin
            d_load    = D_MIN;
            clamp_hit = 1'b1;
        end else if (bus.delay > D_MAX) begin
            d_load    = D_MAX;
            clamp_hit = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        fill_cnt_d = fill_cnt_q;
        d_reg_d    = d_reg_q;
        dout_d     = dout_q;
        clamped_d  = clamped_q;
        if (bus.ce) begin
            wptr_d    = wptr_q + ADDR_WIDTH'(1);
            clamped_d = 1'b0;
            if (bus.delay_load) begin
                // A load always wins, including on the cycle FILL would exit.
                d_reg_d    = d_load;
                clamped_d  = clamp_hit;
                fill_cnt_d = '0;
                state_d    = S_FILL;
            end else begin
                case (state_q)
                    S_FILL: begin
                        if (fill_cnt_q == d_reg_q - (ADDR_WIDTH+1)'(1)) begin
                            state_d = S_RUN;
                        end else begin
                            fill_cnt_d = fill_cnt_q + (ADDR_WIDTH+1)'(1);
                        end
                    end
                    default: begin
                        state_d = S_RUN;
                    end
                endcase
            end
            // Gate on the next state so dout_valid and the first good word
            // appear on the same edge.
            dout_d = (state_d == S_RUN) ? rd_last : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FILL;
            wptr_q     <= '0;
            fill_cnt_q <= '0;
            d_reg_q    <= D_DEF;
            dout_q     <= '0;
            clamped_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            fill_cnt_q <= fill_cnt_d;
            d_reg_q    <= d_reg_d;
            dout_q     <= dout_d;
            clamped_q  <= clamped_d;
        end
    end

    assign bus.dout          = dout_q;
    assign bus.dout_valid    = (state_q == S_RUN);
    assign bus.delay_clamped = clamped_q;
endmodule

// File: tb/tb_bram_delay_var.sv
// tb/tb_bram_delay_var.sv - randomized self-checking bench for bram_delay_var
module tb_bram_delay_var;
    localparam int WIDTH = 128;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;
    localparam int LAT   = 2;
    localparam int DDEF  = 128;

    logic clk;
    logic rst_n;

    bram_delay_var_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) bus ();

    bram_delay_var #(
        .WIDTH(WIDTH), .ADDR_WIDTH(AW), .LATENCY(LAT), .DEFAULT_DELAY(DDEF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: the whole written stream, the current delay, and the number
    // of ce cycles since the last load or reset.
    logic [WIDTH-1:0] hist[$];
    int               m_d;
    int               m_since;
    bit               m_clamped;
    int               idx;

    task automatic check_eq(input string tag, input logic [WIDTH-1:0] obs,
                            input logic [WIDTH-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int clamp_delay(input int dl);
        if (dl < LAT + 1) return LAT + 1;
        if (dl > DEPTH)   return DEPTH;
        return dl;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_d       = DDEF;
        m_since   = 0;
        m_clamped = 1'b0;
    endtask

    task automatic compare_outputs(input string tag);
        bit               exp_valid;
        logic [WIDTH-1:0] exp_dout;
        exp_valid = (m_since >= m_d);
        exp_dout  = exp_valid ? hist[hist.size() - m_d] : '0;
        check_eq({tag, ".valid"},   WIDTH'(bus.dout_valid),    WIDTH'(exp_valid));
        check_eq({tag, ".dout"},    bus.dout,                  exp_dout);
        check_eq({tag, ".clamped"}, WIDTH'(bus.delay_clamped), WIDTH'(m_clamped));
    endtask

    task automatic run_cycle(input string tag, input bit c, input bit ld,
                             input int dl, input logic [WIDTH-1:0] d);
        bus.ce         = c;
        bus.delay_load = ld;
        bus.delay      = (AW+1)'(dl);
        bus.din        = d;
        @(posedge clk);
        if (c) begin
            if (ld) begin
                m_clamped = (clamp_delay(dl) != dl);
                m_d       = clamp_delay(dl);
                m_since   = 0;
            end else begin
                m_clamped = 1'b0;
                m_since++;
            end
            hist.push_back(d);
        end
        @(negedge clk);
        compare_outputs(tag);
    endtask

    function automatic logic [WIDTH-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        rst_n          = 1'b0;
        bus.ce         = 1'b0;
        bus.delay_load = 1'b0;
        bus.delay      = '0;
        bus.din        = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare_outputs("reset");
        rst_n = 1'b1;

        // Counting stream through the default delay.
        idx = 0;
        repeat (140) begin
            run_cycle("t1", 1'b1, 1'b0, 0, WIDTH'(idx));
            idx++;
        end

        // Short delay loaded while running.
        run_cycle("t2_load", 1'b1, 1'b1, 5, WIDTH'(idx)); idx++;
        repeat (20) begin
            run_cycle("t2", 1'b1, 1'b0, 0, WIDTH'(idx));
            idx++;
        end

        // Clamp at both ends.
        run_cycle("t3_lo", 1'b1, 1'b1, 1, rnd_word());
        repeat (8) run_cycle("t3a", 1'b1, 1'b0, 0, rnd_word());
        run_cycle("t3_hi", 1'b1, 1'b1, 2000, rnd_word());

        // Full-depth delay under 50% ce across several pointer wraps.
        repeat (5200) run_cycle("t4", 1'(($urandom & 1)), 1'b0, 0, rnd_word());

        // Load with ce low is ignored; load on the final FILL cycle restarts.
        run_cycle("t6_ce0", 1'b0, 1'b1, 7, rnd_word());
        repeat (4) run_cycle("t6a", 1'b1, 1'b0, 0, rnd_word());
        run_cycle("t6_load10", 1'b1, 1'b1, 10, rnd_word());
        repeat (9) run_cycle("t6b", 1'b1, 1'b0, 0, rnd_word());
        run_cycle("t6_lastfill", 1'b1, 1'b1, 6, rnd_word());
        repeat (12) run_cycle("t6c", 1'b1, 1'b0, 0, rnd_word());

        // Asynchronous reset between edges while running.
        #2 rst_n = 1'b0;
        #1;
        check_eq("t5_async.dout",    bus.dout,                  '0);
        check_eq("t5_async.valid",   WIDTH'(bus.dout_valid),    '0);
        check_eq("t5_async.clamped", WIDTH'(bus.delay_clamped), '0);
        model_reset();
        #1 rst_n = 1'b1;
        repeat (135) run_cycle("t5_refill", 1'b1, 1'b0, 0, rnd_word());

        // Random mix of ce, loads and delays (including out-of-range).
        repeat (4000) begin
            bit c;
            bit ld;
            int dl;
            c  = ($urandom_range(0, 3) != 0);
            ld = ($urandom_range(0, 149) == 0);
            dl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2047))
                                             : int'($urandom_range(0, 40));
            run_cycle("rand", c, ld, dl, rnd_word());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
